// File: rtl/agg_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// agg_fetch_scheduler
//
// Shares one word aggregator among NUM_REQ requesters. A round-robin pointer
// picks the next requester while idle. The scheduler then latches that
// requester's fetch width and word count, and loads the width into the
// aggregator with a one-cycle change_fetch_width pulse. After one settle cycle
// it enables the aggregator until the requested number of output words
// (agg_receiver_enq strobes) has been seen. It then pulses done to the owner.
// A request whose width is 0 or above MAX_FETCH is rejected: it gets
// err_bad_width and done, but no grant.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req                 per-requester request level
//   req_fetch_width     3 bits per requester, requester i at [3i+2:3i]
//   req_len             LEN_WIDTH bits per requester (word count)
//   agg_receiver_enq    aggregator output-word strobe
//   grant               one-hot owner of the aggregator, or zero
//   done                one-cycle completion pulse per requester
//   change_fetch_width  one-cycle width-load pulse to the aggregator
//   input_fetch_width   width presented with change_fetch_width
//   agg_enable          aggregator enable, high only while running
//   busy                high whenever a transaction is in progress
//   err_bad_width       one-cycle pulse on a rejected request
// -----------------------------------------------------------------------------
module agg_fetch_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int LEN_WIDTH = 10,
    parameter int MAX_FETCH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [3*NUM_REQ-1:0]         req_fetch_width,
    input  logic [LEN_WIDTH*NUM_REQ-1:0] req_len,
    input  logic                         agg_receiver_enq,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         change_fetch_width,
    output logic [2:0]                   input_fetch_width,
    output logic                         agg_enable,
    output logic                         busy,
    output logic                         err_bad_width
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0]       MAX_W    = 3'(MAX_FETCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [LEN_WIDTH-1:0] count_reg;

    // Candidate k is requester (rr_ptr + k) mod NUM_REQ. The lowest k with
    // a pending request wins.
    logic [IDX_W-1:0]     cand_idx  [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;
    logic [2:0]           width_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0] len_arr   [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [IDX_W:0] sum;
            assign sum           = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (IDX_W+1)'(NUM_REQ))
                                 ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                 : IDX_W'(sum);
            assign cand_hit[gi]  = req[cand_idx[gi]];
            assign width_arr[gi] = req_fetch_width[3*gi +: 3];
            assign len_arr[gi]   = req_len[LEN_WIDTH*gi +: LEN_WIDTH];
        end
    endgenerate

    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic [2:0]           sel_width;
    logic [LEN_WIDTH-1:0] sel_len;
    logic                 sel_legal;
    logic [IDX_W-1:0]     next_ptr;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx[k];
            end
        end
    end

    assign sel_width = width_arr[sel_idx];
    assign sel_len   = len_arr[sel_idx];
    assign sel_legal = (sel_width != 3'd0) && (sel_width <= MAX_W);
    assign next_ptr  = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

    // All outputs are registered. Each one is set on the edge that enters the
    // state in which it must be visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            rr_ptr_reg         <= '0;
            idx_reg            <= '0;
            len_reg            <= '0;
            count_reg          <= '0;
            grant              <= '0;
            done               <= '0;
            change_fetch_width <= 1'b0;
            input_fetch_width  <= 3'd0;
            agg_enable         <= 1'b0;
            busy               <= 1'b0;
            err_bad_width      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        idx_reg   <= sel_idx;
                        len_reg   <= sel_len;
                        count_reg <= '0;
                        busy      <= 1'b1;
                        state_reg <= CONFIG;
                        if (sel_legal) begin
                            grant              <= NUM_REQ'(1) << sel_idx;
                            change_fetch_width <= 1'b1;
                            input_fetch_width  <= sel_width;
                        end else begin
                            err_bad_width <= 1'b1;
                            done          <= NUM_REQ'(1) << sel_idx;
                        end
                    end
                end
                CONFIG: begin
                    change_fetch_width <= 1'b0;
                    input_fetch_width  <= 3'd0;
                    if (err_bad_width) begin
                        // Rejected request: its pulses end here, back to idle.
                        err_bad_width <= 1'b0;
                        done          <= '0;
                        busy          <= 1'b0;
                        rr_ptr_reg    <= next_ptr;
                        state_reg     <= IDLE;
                    end else if (len_reg == '0) begin
                        grant     <= '0;
                        done      <= NUM_REQ'(1) << idx_reg;
                        state_reg <= DONE;
                    end else begin
                        state_reg <= SETTLE;
                    end
                end
                SETTLE: begin
                    // The aggregator picks up the new width during this cycle.
                    agg_enable <= 1'b1;
                    state_reg  <= RUN;
                end
                RUN: begin
                    if (agg_receiver_enq) begin
                        // The strobe arriving with count == len-1 is the final word.
                        if (count_reg == len_reg - LEN_WIDTH'(1)) begin
                            agg_enable <= 1'b0;
                            grant      <= '0;
                            done       <= NUM_REQ'(1) << idx_reg;
                            state_reg  <= DONE;
                        end else begin
                            count_reg <= count_reg + LEN_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done       <= '0;
                    busy       <= 1'b0;
                    count_reg  <= '0;
                    rr_ptr_reg <= next_ptr;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_agg_fetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_agg_fetch_scheduler
//
// Directed tests with hand-computed expected values. They cover a single
// request, the round-robin order, illegal widths, zero length, reset during a
// run and stray strobes.
// -----------------------------------------------------------------------------
module tb_agg_fetch_scheduler;

    localparam int NUM_REQ   = 3;
    localparam int LEN_WIDTH = 10;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_REQ-1:0]           req = '0;
    logic [3*NUM_REQ-1:0]         req_fetch_width = '0;
    logic [LEN_WIDTH*NUM_REQ-1:0] req_len = '0;
    logic                         agg_receiver_enq = 1'b0;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic                         change_fetch_width;
    logic [2:0]                   input_fetch_width;
    logic                         agg_enable;
    logic                         busy;
    logic                         err_bad_width;

    agg_fetch_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_FETCH (6)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .req_fetch_width    (req_fetch_width),
        .req_len            (req_len),
        .agg_receiver_enq   (agg_receiver_enq),
        .grant              (grant),
        .done               (done),
        .change_fetch_width (change_fetch_width),
        .input_fetch_width  (input_fetch_width),
        .agg_enable         (agg_enable),
        .busy               (busy),
        .err_bad_width      (err_bad_width)
    );

    always #5 clk = ~clk;

    int vectors_applied = 0;
    int miscompares     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] w, input logic [LEN_WIDTH-1:0] l);
        req_fetch_width[3*i +: 3]           = w;
        req_len[LEN_WIDTH*i +: LEN_WIDTH]   = l;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"}, 32'(grant), 0);
        check({tag, ".done"},  32'(done), 0);
        check({tag, ".cfw"},   32'(change_fetch_width), 0);
        check({tag, ".ifw"},   32'(input_fetch_width), 0);
        check({tag, ".agg_en"},32'(agg_enable), 0);
        check({tag, ".busy"},  32'(busy), 0);
        check({tag, ".err"},   32'(err_bad_width), 0);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        $display("txn reset: outputs idle after reset");

        // ---------------- single request, width 6, len 2 ----------------
        set_req(0, 3'd6, 10'd2);
        req = 3'b001;
        tick();                                  // CONFIG
        check("single.cfg.grant", 32'(grant), 1);
        check("single.cfg.cfw",   32'(change_fetch_width), 1);
        check("single.cfg.ifw",   32'(input_fetch_width), 6);
        check("single.cfg.busy",  32'(busy), 1);
        check("single.cfg.agg",   32'(agg_enable), 0);
        req = 3'b000;
        set_req(0, 3'd2, 10'd7);                 // must not affect the latched values
        tick();                                  // SETTLE
        check("single.settle.cfw",   32'(change_fetch_width), 0);
        check("single.settle.agg",   32'(agg_enable), 0);
        check("single.settle.grant", 32'(grant), 1);
        tick();                                  // RUN, two cycles after cfw
        check("single.run.agg", 32'(agg_enable), 1);
        agg_receiver_enq = 1'b1;
        tick();                                  // first word
        check("single.enq1.agg",  32'(agg_enable), 1);
        check("single.enq1.done", 32'(done), 0);
        tick();                                  // second word -> DONE
        check("single.done.done",  32'(done), 1);
        check("single.done.grant", 32'(grant), 0);
        check("single.done.agg",   32'(agg_enable), 0);
        agg_receiver_enq = 1'b0;
        tick();                                  // IDLE
        check("single.idle.done", 32'(done), 0);
        check("single.idle.busy", 32'(busy), 0);
        $display("txn single: req0 width 6 len 2");

        // ---------------- round robin, all requesting, len 1 ----------------
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'd1, 10'd1);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_oh;
            exp_oh = 32'(1) << (k % NUM_REQ);
            tick();                              // CONFIG
            check("rr.cfg.grant", 32'(grant), exp_oh);
            tick();                              // SETTLE
            tick();                              // RUN
            check("rr.run.grant", 32'(grant), exp_oh);
            agg_receiver_enq = 1'b1;
            tick();                              // DONE
            check("rr.done.done",  32'(done), exp_oh);
            check("rr.done.grant", 32'(grant), 0);
            agg_receiver_enq = 1'b0;
            tick();                              // IDLE gap
            check("rr.idle.grant", 32'(grant), 0);
            check("rr.idle.busy",  32'(busy), 0);
            $display("txn rr: grant to requester %0d", k % NUM_REQ);
        end

        // ---------------- illegal width 7 on req1, then req2 ----------------
        set_req(1, 3'd7, 10'd1);
        set_req(2, 3'd2, 10'd1);
        req = 3'b110;                            // rr_ptr is 1
        tick();                                  // CONFIG, rejected
        check("bad.err",   32'(err_bad_width), 1);
        check("bad.done",  32'(done), 3'b010);
        check("bad.grant", 32'(grant), 0);
        check("bad.cfw",   32'(change_fetch_width), 0);
        tick();                                  // IDLE
        check("bad.idle.err",  32'(err_bad_width), 0);
        check("bad.idle.done", 32'(done), 0);
        tick();                                  // CONFIG for req2
        check("bad.next.grant", 32'(grant), 3'b100);
        check("bad.next.ifw",   32'(input_fetch_width), 2);
        req = 3'b000;
        tick();                                  // SETTLE
        tick();                                  // RUN
        agg_receiver_enq = 1'b1;
        tick();                                  // DONE
        check("bad.next.done", 32'(done), 3'b100);
        agg_receiver_enq = 1'b0;
        tick();                                  // IDLE, rr_ptr 0
        $display("txn bad_width: req1 width 7 rejected, req2 served");

        // ---------------- zero length on req2 ----------------
        set_req(2, 3'd3, 10'd0);
        req = 3'b100;
        tick();                                  // CONFIG
        check("zero.cfg.grant", 32'(grant), 3'b100);
        check("zero.cfg.ifw",   32'(input_fetch_width), 3);
        req = 3'b000;
        tick();                                  // DONE
        check("zero.done.done", 32'(done), 3'b100);
        check("zero.done.agg",  32'(agg_enable), 0);
        check("zero.done.grant",32'(grant), 0);
        tick();                                  // IDLE, rr_ptr 0
        check("zero.idle.done", 32'(done), 0);
        $display("txn zero_len: req2 len 0");

        // ---------------- stray enq in IDLE and SETTLE ----------------
        set_req(0, 3'd4, 10'd3);
        agg_receiver_enq = 1'b1;
        tick();                                  // still IDLE
        check("stray.idle.busy", 32'(busy), 0);
        agg_receiver_enq = 1'b0;
        req = 3'b001;
        tick();                                  // CONFIG
        check("stray.cfg.ifw", 32'(input_fetch_width), 4);
        req = 3'b000;
        tick();                                  // SETTLE
        agg_receiver_enq = 1'b1;
        tick();                                  // RUN (settle strobe ignored)
        check("stray.run.agg", 32'(agg_enable), 1);
        tick();                                  // word 1
        tick();                                  // word 2
        check("stray.w2.done", 32'(done), 0);
        check("stray.w2.agg",  32'(agg_enable), 1);
        tick();                                  // word 3 -> DONE
        check("stray.w3.done", 32'(done), 3'b001);
        agg_receiver_enq = 1'b0;
        tick();                                  // IDLE, rr_ptr 1
        $display("txn stray_enq: req0 len 3 after stray strobes");

        // ---------------- reset during RUN ----------------
        set_req(0, 3'd2, 10'd4);
        req = 3'b001;
        tick();                                  // CONFIG
        req = 3'b000;
        tick();                                  // SETTLE
        tick();                                  // RUN
        agg_receiver_enq = 1'b1;
        tick();                                  // word 1 of 4
        agg_receiver_enq = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        set_req(0, 3'd5, 10'd1);
        set_req(1, 3'd5, 10'd1);
        req = 3'b011;                            // rr_ptr back at 0 -> req0 first
        tick();                                  // CONFIG
        check("midrst.cfg.grant", 32'(grant), 3'b001);
        check("midrst.cfg.ifw",   32'(input_fetch_width), 5);
        req = 3'b000;
        tick();                                  // SETTLE
        tick();                                  // RUN
        agg_receiver_enq = 1'b1;
        tick();                                  // DONE
        check("midrst.done", 32'(done), 3'b001);
        agg_receiver_enq = 1'b0;
        tick();                                  // IDLE, rr_ptr 1
        $display("txn mid_reset: abandoned run, req0 served after reset");

        // ---------------- width 0 is rejected ----------------
        set_req(0, 3'd0, 10'd3);
        req = 3'b001;
        tick();                                  // CONFIG, rejected
        check("w0.err",   32'(err_bad_width), 1);
        check("w0.done",  32'(done), 3'b001);
        check("w0.grant", 32'(grant), 0);
        check("w0.cfw",   32'(change_fetch_width), 0);
        req = 3'b000;
        tick();                                  // IDLE
        check("w0.idle.err",  32'(err_bad_width), 0);
        check("w0.idle.busy", 32'(busy), 0);
        $display("txn width0: req0 width 0 rejected");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
